data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning data path and bus data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning word address width.
REQ-003 The block SHALL have parameter WBUF_DEPTH, default 4, meaning posted-write buffer entries (power of 2, >=2).
REQ-004 The block SHALL have a single clock domain and an asynchronous, active-high reset, with ports as listed below.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 addr  input  ADDR_W  CPU access word address.
REQ-008 we / re  input  1 each  CPU write / read request, level, held until busy low.
REQ-009 data  input  DATA_W  CPU write data.
REQ-010 hold  input  1  pipeline stall; blocks acceptance of new CPU requests.
REQ-011 q  output  DATA_W  read data.
REQ-012 busy  output  1  CPU must stall while high.
REQ-013 wbuf_empty  output  1  write buffer empty and no write in flight (fence status).
REQ-014 bus_addr / bus_data  output  ADDR_W / DATA_W  bus request address / write data.
REQ-015 bus_we, bus_start  output  1 each  bus write strobe, transaction request.
REQ-016 bus_q, bus_done  input  DATA_W, 1  bus read data, one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, WR_BUS (draining buffer head), RD_BUS.
REQ-018 The block SHALL accept a write (we=1, hold=0) in the same cycle when buffer not full: enqueue {addr,data}, busy=0.
REQ-019 The block SHALL assert busy combinationally for a write while buffer full; enqueue in the first cycle a slot exists (pop and push same cycle allowed).
REQ-020 The block SHALL treat we=1 and re=1 together as a write only.
REQ-021 In IDLE with buffer non-empty, the block SHALL move to WR_BUS next cycle presenting the head entry.
REQ-022 A read (re=1, hold=0) SHALL keep busy=1 until the buffer fully drains, then enter RD_BUS (loads never pass stores).
REQ-023 bus_start SHALL be 1 in WR_BUS/RD_BUS gated by !bus_done, else 0; bus_addr/bus_data/bus_we stable while bus_start=1; bus_we=1 only in WR_BUS.
REQ-024 On bus_done in WR_BUS the block SHALL pop the head and return to IDLE (minimum one IDLE cycle between bus transactions).
REQ-025 On bus_done in RD_BUS the block SHALL drive q=bus_q and busy=0 that cycle, capture bus_q into a held register, return to IDLE.
REQ-026 Outside a bus_done read cycle, q SHALL equal the last captured read value.
REQ-027 hold=1 SHALL block new enqueues and new reads but SHALL NOT abort or delay an in-flight bus transaction or draining.
REQ-028 bus_done outside WR_BUS/RD_BUS SHALL be ignored.
REQ-029 wbuf_empty SHALL be 1 only when count=0 and state!=WR_BUS.

Reset
REQ-030 Reset SHALL immediately force state IDLE, pointers/count 0 (buffered writes discarded), q register 0, bus_start 0, busy 0, wbuf_empty 1, even mid-transaction.

Configuration
REQ-031 With DATAMEM_STORE_FWD_EN defined, a read whose addr matches any buffered entry SHALL return the youngest matching data combinationally with busy=0, no bus read, no drain wait; without it, REQ-022 applies to all reads.

Verification
REQ-032 Reset, 4 writes addr 0x10..0x13 data 0xA0..0xA3, bus_done 2 cycles after each bus_start -> busy never high, bus sees 4 writes in order, wbuf_empty=1 afterwards.
REQ-033 5 back-to-back writes, bus_done withheld -> busy high on 5th write until first bus_done, then 5th enqueued that cycle.
REQ-034 Write 0x20=0x55 then read 0x30, bus_q=0x1234 -> write issued first, then read; q=0x1234 on bus_done and held after.
REQ-035 Forward build: write 0x40=0x77, write 0x40=0x88, read 0x40 -> q=0x88, busy=0, no read bus_start; non-forward build -> drains both, then bus read.
REQ-036 Assert reset while in RD_BUS -> bus_start 0 immediately, q=0, wbuf_empty=1; stray later bus_done ignored.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory controller with a posted-write buffer in front of a simple
// request/done bus. Writes are absorbed into the buffer without stalling
// unless it is full. Reads wait until the buffer has drained, so loads never
// overtake older stores.
//
// Optional build macro: DATAMEM_STORE_FWD_EN
//   When defined, a read that hits a buffered address returns the youngest
//   matching data in the same cycle. It does not wait for the drain and issues
//   no bus read.
//
// state  | meaning
// IDLE   | no bus transaction; drains the buffer head if one is waiting
// WR_BUS | buffer head presented on the bus as a write, waiting for bus_done
// RD_BUS | CPU read presented on the bus, waiting for bus_done
module data_mem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              re,
    input  logic [DATA_W-1:0] data,
    input  logic              hold,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              wbuf_empty,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done
);

    localparam int             PTR_W    = $clog2(WBUF_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(WBUF_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_BUS = 2'd1,
        RD_BUS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   buf_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0]   buf_data_q [WBUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [DATA_W-1:0]   q_q, q_d;

    logic                wr_req, rd_req, full, push, pop, rd_done;
    logic                fwd_hit, fwd_rd;
    logic [DATA_W-1:0]   fwd_data;

    // A simultaneous we/re is treated as a write; hold masks both requests.
    assign wr_req  = we && !hold;
    assign rd_req  = re && !we && !hold;
    assign full    = (count_q == CNT_FULL);
    assign pop     = (state_q == WR_BUS) && bus_done;
    assign push    = wr_req && (!full || pop);
    assign rd_done = (state_q == RD_BUS) && bus_done;
    assign fwd_rd  = rd_req && fwd_hit;

`ifdef DATAMEM_STORE_FWD_EN
    // Scan the buffer from oldest to youngest so that the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (((PTR_W+1)'(k) < count_q) &&
                (buf_addr_q[rd_ptr_q + PTR_W'(k)] == addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // Occupancy bookkeeping; a pop and a push in the same cycle cancel out.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Read data: live bus data (or forwarded data) in its own cycle, held value otherwise.
    always_comb begin
        q_d = q_q;
        if (rd_done) begin
            q_d = bus_q;
        end else if (fwd_rd) begin
            q_d = fwd_data;
        end
    end

    assign q = q_d;

    // Next state and bus/CPU outputs. Draining the buffer takes priority over a read.
    always_comb begin
        state_d    = state_q;
        bus_start  = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = rd_addr_q;
        bus_data   = '0;
        busy       = 1'b0;
        wbuf_empty = (count_q == '0) && (state_q != WR_BUS);

        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = WR_BUS;
                end else if (rd_req && !fwd_hit) begin
                    state_d = RD_BUS;
                end
            end
            WR_BUS: begin
                bus_start = !bus_done;
                bus_we    = 1'b1;
                bus_addr  = buf_addr_q[rd_ptr_q];
                bus_data  = buf_data_q[rd_ptr_q];
                if (bus_done) begin
                    state_d = IDLE;
                end
            end
            RD_BUS: begin
                bus_start = !bus_done;
                if (bus_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr_req) begin
            busy = !push;
        end else if (rd_req) begin
            busy = !fwd_rd && !rd_done;
        end
        if (reset) begin
            busy = 1'b0;
        end
    end

    // State, buffer pointers, captured read address and held read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            q_q       <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            q_q     <= q_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if ((state_q == IDLE) && (state_d == RD_BUS)) begin
                rd_addr_q <= addr;
            end
        end
    end

    // Buffer storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= addr;
            buf_data_q[wr_ptr_q] <= data;
        end
    end

endmodule
